// File: rtl/mem_access_unit_if.sv
// Bus bundle between the control FSM / data memory and mem_access_unit.
// slave is the mem_access_unit view; master is the environment view
// (control FSM request side plus the data memory response side).
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_funct3;
  logic              req_ready;
  logic              busy;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
    output req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
    input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store adapter: decodes byte/half/word accesses, drives a variable
// latency word memory, formats load data and flags misaligned, illegal and
// timed-out accesses. All outputs are registered.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        dec_bad_c;
  logic [3:0]  dec_be_c;
  logic [31:0] dec_wdata_c;
  logic [31:0] load_data_c;
  logic [31:0] lane_word_c;

  // Request decode: legality, alignment, byte enables and lane-shifted data.
  always_comb begin
    dec_bad_c   = 1'b0;
    dec_be_c    = 4'b1111;
    dec_wdata_c = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
    if (bus.req_write) begin
      if (bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11)) dec_bad_c = 1'b1;
    end else begin
      if ((bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110)) dec_bad_c = 1'b1;
    end
    case (bus.req_funct3[1:0])
      2'b01:   if (bus.req_addr[0]) dec_bad_c = 1'b1;
      2'b10:   if (bus.req_addr[1:0] != 2'b00) dec_bad_c = 1'b1;
      default: ;
    endcase
    if (bus.req_write) begin
      case (bus.req_funct3[1:0])
        2'b00:   dec_be_c = 4'b0001 << bus.req_addr[1:0];
        2'b01:   dec_be_c = 4'b0011 << bus.req_addr[1:0];
        default: dec_be_c = 4'b1111;
      endcase
    end
  end

  // Load formatting: pick the addressed lane, then sign or zero extend.
  always_comb begin
    lane_word_c = bus.mem_rdata >> {lane_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   load_data_c = funct3_q[2] ? {24'h0, lane_word_c[7:0]}
                                         : {{24{lane_word_c[7]}}, lane_word_c[7:0]};
      2'b01:   load_data_c = funct3_q[2] ? {16'h0, lane_word_c[15:0]}
                                         : {{16{lane_word_c[15]}}, lane_word_c[15:0]};
      default: load_data_c = bus.mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          funct3_d = bus.req_funct3;
          lane_d   = bus.req_addr[1:0];
          cnt_d    = '0;
          if (dec_bad_c) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            rsp_err_d   = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_write;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = dec_be_c;
            mem_wdata_d = dec_wdata_c;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rsp_err_d = 1'b0;
          if (!mem_we_q) rsp_rdata_d = load_data_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      lane_q      <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [31:0] exp_rdata;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b exp 0", bus.mem_req); end
    n_chk++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h exp 0", bus.rsp_rdata); end
    n_chk++; if (bus.mem_be !== 4'h0) begin n_fail++; $display("FAIL reset_mem_be: got %b exp 0000", bus.mem_be); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(1'b0, 32'h100, 32'h0, 3'b010);
    n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_mem_req: got %b exp 1", bus.mem_req); end
    n_chk++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL lw_mem_addr: got %h exp 00000100", bus.mem_addr); end
    n_chk++; if (bus.mem_be !== 4'b1111) begin n_fail++; $display("FAIL lw_mem_be: got %b exp 1111", bus.mem_be); end
    n_chk++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_mem_we: got %b exp 0", bus.mem_we); end
    n_chk++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL lw_busy_ready: got %b/%b exp 1/0", bus.busy, bus.req_ready); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack   = 1'b0;
    exp_rdata = 32'hDEADBEEF;
    n_chk++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lw_rsp_valid: got %b exp 1", bus.rsp_valid); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL lw_rsp_rdata: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    n_chk++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL lw_rsp_err: got %b exp 0", bus.rsp_err); end
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_mem_req_drop: got %b exp 0", bus.mem_req); end
    tick();
    n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_back_idle: valid/ready got %b/%b exp 0/1", bus.rsp_valid, bus.req_ready); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL lw_rdata_hold: got %h exp %h", bus.rsp_rdata, exp_rdata); end
  endtask

  task automatic test_load_ext();
    logic [31:0] addrs [5] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h200};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008011, 32'hFFFF8011, 32'h00000033};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, addrs[i], 32'h0, f3s[i]);
      n_chk++; if (bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL ext_mem_addr[%0d]: got %h exp 00000200", i, bus.mem_addr); end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h80112233;
      tick();
      bus.mem_ack   = 1'b0;
      exp_rdata = exps[i];
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL ext_rsp[%0d]: valid/err got %b/%b exp 1/0", i, bus.rsp_valid, bus.rsp_err); end
      n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL ext_rdata[%0d]: got %h exp %h", i, bus.rsp_rdata, exp_rdata); end
      tick();
    end
  endtask

  task automatic test_store_wait();
    issue(1'b1, 32'h0A2, 32'h1234ABCD, 3'b001);
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sh_req_we[%0d]: got %b/%b exp 1/1", i, bus.mem_req, bus.mem_we); end
      n_chk++; if (bus.mem_addr !== 32'h0A0) begin n_fail++; $display("FAIL sh_mem_addr[%0d]: got %h exp 000000a0", i, bus.mem_addr); end
      n_chk++; if (bus.mem_be !== 4'b1100) begin n_fail++; $display("FAIL sh_mem_be[%0d]: got %b exp 1100", i, bus.mem_be); end
      n_chk++; if (bus.mem_wdata !== 32'hABCD0000) begin n_fail++; $display("FAIL sh_mem_wdata[%0d]: got %h exp abcd0000", i, bus.mem_wdata); end
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sh_early_rsp[%0d]: got %b exp 0", i, bus.rsp_valid); end
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL sh_rsp: valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL sh_rdata_kept: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_mem_req_drop: got %b exp 0", bus.mem_req); end
    tick();
  endtask

  task automatic test_errors();
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] addrs [4] = '{32'h102, 32'h100, 32'h201, 32'h200};
    logic [2:0]  f3s   [4] = '{3'b010, 3'b011, 3'b101, 3'b110};
    for (int i = 0; i < 4; i++) begin
      issue(wrs[i], addrs[i], 32'h55, f3s[i]);
      n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL err_no_req[%0d]: got %b exp 0", i, bus.mem_req); end
      n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_rsp[%0d]: valid/err got %b/%b exp 1/1", i, bus.rsp_valid, bus.rsp_err); end
      n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL err_rdata_kept[%0d]: got %h exp %h", i, bus.rsp_rdata, exp_rdata); end
      tick();
      n_chk++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL err_idle[%0d]: valid/ready got %b/%b exp 0/1", i, bus.rsp_valid, bus.req_ready); end
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_chk++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_ack: busy/valid got %b/%b exp 0/0", bus.busy, bus.rsp_valid); end
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h300, 32'h0, 3'b010);
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bus.mem_req !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait[%0d]: req/valid got %b/%b exp 1/0", i, bus.mem_req, bus.rsp_valid); end
      tick();
    end
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b exp 0", bus.mem_req); end
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL to_rsp: valid/err got %b/%b exp 1/1", bus.rsp_valid, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL to_rdata_kept: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    tick();
    issue(1'b0, 32'h304, 32'h0, 3'b010);
    for (int i = 0; i < 16; i++) begin
      n_chk++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL to_ack_wait[%0d]: got %b exp 1", i, bus.mem_req); end
      if (i == 15) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5A5A0001;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    exp_rdata = 32'h5A5A0001;
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL to_ack_wins: valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL to_ack_rdata: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h400, 32'h0, 3'b010);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rdata = 32'h0;
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_req: got %b exp 0", bus.mem_req); end
    n_chk++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: ready/busy got %b/%b exp 1/0", bus.req_ready, bus.busy); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rst_mid_rdata: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_rsp[%0d]: got %b exp 0", i, bus.rsp_valid); end
      tick();
    end
    issue(1'b1, 32'h3, 32'hAA, 3'b000);
    n_chk++; if (bus.mem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_mem_be: got %b exp 1000", bus.mem_be); end
    n_chk++; if (bus.mem_wdata !== 32'hAA000000) begin n_fail++; $display("FAIL sb_mem_wdata: got %h exp aa000000", bus.mem_wdata); end
    n_chk++; if (bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sb_addr_we: got %h/%b exp 00000000/1", bus.mem_addr, bus.mem_we); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL sb_rsp: valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
    n_chk++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL sb_rdata_kept: got %h exp %h", bus.rsp_rdata, exp_rdata); end
    tick();
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    exp_rdata      = 32'h0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_load_ext();
    test_store_wait();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
